// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;
  // Canonical RV32 NOP (addi x0, x0, 0), shown to decode when nothing is buffered
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // One buffered fetch: instruction word plus the address it came from
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_ent_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {inst, pc} pairs; flush empties it.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy update; flush wins over push/pop (a same-cycle pop has already been consumed)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      assert (!(i_push && !i_flush && r_count == CW'(DEPTH)));
      if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (i_push) r_wptr <= ptr_inc(r_wptr);
        if (i_pop)  r_rptr <= ptr_inc(r_rptr);
        case ({i_push, i_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: PC, credit-based issue to sync imem, redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_inflight;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;
  logic          w_valid, w_pop, w_push, w_issue;
  fetch_ent_t    w_head, w_wr;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & inst_ready_i;
  assign w_push  = r_inflight & ~redirect_i;

  // Slots committed after this cycle: buffered + in flight - leaving now; pop frees a slot immediately
  assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue = rst_ni & ~redirect_i & (w_occ < (CW+1)'(DEPTH));

  assign w_wr = '{inst: imem_rdata_i, pc: r_req_pc};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  (w_wr),
    .o_count (w_count),
    .o_data  (w_head)
  );

  // PC advance / redirect and tracking of the single outstanding request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_req_pc <= r_pc;
      if (redirect_i)   r_pc <= {redirect_pc_i[31:2], 2'b00};
      else if (w_issue) r_pc <= r_pc + 32'd4;
    end
  end

  assign imem_req_o   = w_issue;
  assign imem_addr_o  = r_pc;
  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? w_head.inst : NOP_INST;
  assign pc_o         = w_valid ? w_head.pc   : 32'h0;
endmodule
